// File: rtl/bw_io_impctl_pkg.sv
// Shared types and helpers for the multi-channel impedance-control averaging counter.
package bw_io_impctl_pkg;

  // Averaging FSM: accumulate samples, or wait for the consumer to accept a result.
  typedef enum logic [0:0] {
    COUNT = 1'b0,
    HOLD  = 1'b1
  } avg_state_e;

  // Default window length and the width of its sample counter.
  localparam int WIN_DEFAULT = 256;
  localparam int WIN_W       = $clog2(WIN_DEFAULT);

  // Re-centre value of a counter of the given width: 2^(width-1).
  function automatic int avg_mid(input int width);
    return 1 << (width - 1);
  endfunction

  // Bits needed to count 0..win-1, never less than one.
  function automatic int avg_win_w(input int win);
    return (win > 1) ? $clog2(win) : 1;
  endfunction

endpackage

// File: rtl/bw_io_impctl_avgcnt_ch.sv
// One comparator channel: a saturating up/down counter that re-centres on demand,
// plus the hysteresis compare evaluated on the value the counter is about to take.
module bw_io_impctl_avgcnt_ch
  import bw_io_impctl_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int THR   = 8
) (
  input  logic l2clk,
  input  logic avgcntr_rst,
  input  logic step,
  input  logic dir,
  input  logic load_mid,
  output logic up_hit,
  output logic dn_hit,
  output logic sgn
);

  localparam int               MID_I  = avg_mid(WIDTH);
  localparam logic [WIDTH-1:0] MID_V  = MID_I[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_V  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] THR_V  = THR[WIDTH-1:0];
  localparam logic [WIDTH-1:0] UP_LIM = MID_V + THR_V;
  localparam logic [WIDTH-1:0] DN_LIM = MID_V - THR_V;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;

  // Next counter value: one step toward the comparator's direction, clamped at both rails.
  always_comb begin
    cnt_nxt = cnt;
    if (step) begin
      if (dir) begin
        if (cnt != MAX_V) cnt_nxt = cnt + 1'b1;
      end else begin
        if (cnt != MIN_V) cnt_nxt = cnt - 1'b1;
      end
    end
  end

  // The decision must see the final sample of the window, so compare the post-step value.
  always_comb begin
    up_hit = (cnt_nxt >= UP_LIM);
    dn_hit = (cnt_nxt <= DN_LIM);
  end

  // Counter register; re-centres on reset and at the end of every window.
  always_ff @(posedge l2clk) begin
    if (avgcntr_rst || load_mid) begin
      cnt <= MID_V;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign sgn = cnt[WIDTH-1];

endmodule

// File: rtl/bw_io_impctl_avgcnt_mc.sv
// Multi-channel averaging counter: shared sample window, per-channel counters,
// and a valid/ack handshake carrying the per-channel advance-up/advance-down result.
module bw_io_impctl_avgcnt_mc
  import bw_io_impctl_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int WIDTH = 9,
  parameter int WIN   = 256,
  parameter int THR   = 8
) (
  input  logic           l2clk,
  input  logic           avgcntr_rst,
  input  logic           sclk,
  input  logic [NCH-1:0] above,
  input  logic           adv_ack,
  output logic           adv_vld,
  output logic [NCH-1:0] adv_up,
  output logic [NCH-1:0] adv_dn,
  output logic [NCH-1:0] adv_sgn
);

  localparam int             WCW      = avg_win_w(WIN);
  localparam int             WIN_M1   = WIN - 1;
  localparam logic [WCW-1:0] WIN_LAST = WIN_M1[WCW-1:0];
  localparam logic [WCW-1:0] WIN_ONE  = {{(WCW-1){1'b0}}, 1'b1};

  avg_state_e     state;
  logic [WCW-1:0] win_cnt;
  logic           sample;
  logic           last_sample;
  logic [NCH-1:0] up_hit;
  logic [NCH-1:0] dn_hit;

  // Samples only count while accumulating; a strobe during HOLD (including the ack cycle) is dropped.
  always_comb begin
    sample      = (state == COUNT) && sclk;
    last_sample = sample && (win_cnt == WIN_LAST);
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    bw_io_impctl_avgcnt_ch #(
      .WIDTH (WIDTH),
      .THR   (THR)
    ) u_ch (
      .l2clk       (l2clk),
      .avgcntr_rst (avgcntr_rst),
      .step        (sample),
      .dir         (above[g]),
      .load_mid    (last_sample),
      .up_hit      (up_hit[g]),
      .dn_hit      (dn_hit[g]),
      .sgn         (adv_sgn[g])
    );
  end

  // Window counter, FSM and result registers; reset discards any pending result.
  always_ff @(posedge l2clk) begin
    if (avgcntr_rst) begin
      state   <= COUNT;
      win_cnt <= '0;
      adv_vld <= 1'b0;
      adv_up  <= '0;
      adv_dn  <= '0;
    end else begin
      case (state)
        COUNT: begin
          if (last_sample) begin
            win_cnt <= '0;
            adv_vld <= 1'b1;
            adv_up  <= up_hit;
            adv_dn  <= dn_hit;
            state   <= HOLD;
          end else if (sample) begin
            win_cnt <= win_cnt + WIN_ONE;
          end
        end
        HOLD: begin
          if (adv_ack) begin
            adv_vld <= 1'b0;
            adv_up  <= '0;
            adv_dn  <= '0;
            state   <= COUNT;
          end
        end
        default: begin
          state <= COUNT;
        end
      endcase
    end
  end

endmodule
